ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. Consumes the instruction fields produced by the combinational instruction decoder (opcode, funct3, funct7) and drives the datapath's enables and selects through fetch, decode, execute, memory and write-back phases. It also owns the shared instruction/data memory request handshake and flags illegal instructions.

---
 rtl/ctrl_pkg.sv | 93 +++++++++
 rtl/ctrl_aludec.sv | 49 ++++
 rtl/ctrl.sv | 174 +++++++++++++++++
 tb/tb_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32I multi-cycle control sequencer.
//   - RV32I major opcode constants
//   - sequencer state enum (TRAP state only exists when CTRL_TRAP_EN is defined)
//   - ALU operation, immediate format and register write-data select encodings
//   - ctrl_sig_t: bundle of every datapath control output
//   - insn_illegal(): legality of opcode/funct3 given the OP/OP-IMM legality bit
package ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
`ifdef CTRL_TRAP_EN
      , ST_TRAP
`endif
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WSEL_ALU = 2'd0;
   localparam logic [1:0] WSEL_MEM = 2'd1;
   localparam logic [1:0] WSEL_PC4 = 2'd2;

   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic       rf_we;
      logic [1:0] rf_wsel;
      logic [3:0] alu_op;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] imm_sel;
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic [1:0] mem_size;
      logic       retire;
      logic       trap;
   } ctrl_sig_t;

   // alu_legal carries the funct7 checks for OP/OP-IMM; everything else is
   // decided from opcode and funct3 alone. Unlisted opcodes (including
   // SYSTEM and anything with opcode[1:0] != 2'b11) fall to the default.
   function automatic logic insn_illegal(input logic [6:0] opc,
                                         input logic [2:0] f3,
                                         input logic       alu_legal);
      case (opc)
         OPC_OP, OPC_OPIMM:                      insn_illegal = !alu_legal;
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: insn_illegal = 1'b0;
         OPC_LOAD:   insn_illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         OPC_STORE:  insn_illegal = (f3 > 3'b010);
         OPC_BRANCH: insn_illegal = (f3[2:1] == 2'b01);
         OPC_JALR:   insn_illegal = (f3 != 3'b000);
         default:    insn_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_aludec.sv
// ctrl_aludec: combinational ALU operation decode.
//   i_opcode/i_funct3/i_funct7 : instruction fields
//   o_alu_op                   : ALU operation (ctrl_pkg encoding)
//   o_alu_legal                : 0 when an OP/OP-IMM funct7 is not a valid RV32I encoding
// Non-OP opcodes decode to ADD (address/target computation), LUI to PASS_B.
module ctrl_aludec
   import ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output logic [3:0] o_alu_op,
   output logic       o_alu_legal
);

   logic is_op, is_imm;

   assign is_op  = (i_opcode == OPC_OP);
   assign is_imm = (i_opcode == OPC_OPIMM);

   always_comb begin
      o_alu_op    = ALU_ADD;
      o_alu_legal = 1'b1;
      if (i_opcode == OPC_LUI) begin
         o_alu_op = ALU_PASS_B;
      end else if (is_op || is_imm) begin
         case (i_funct3)
            // funct7[5] selects SUB only for register-register; for ADDI it is immediate bits
            3'b000: o_alu_op = (is_op && i_funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: o_alu_op = ALU_SLL;
            3'b010: o_alu_op = ALU_SLT;
            3'b011: o_alu_op = ALU_SLTU;
            3'b100: o_alu_op = ALU_XOR;
            3'b101: o_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: o_alu_op = ALU_OR;
            3'b111: o_alu_op = ALU_AND;
         endcase
         if (is_op)
            o_alu_legal = (i_funct7 == 7'b0000000) ||
                          ((i_funct7 == 7'b0100000) &&
                           ((i_funct3 == 3'b000) || (i_funct3 == 3'b101)));
         else if (i_funct3 == 3'b001)
            o_alu_legal = (i_funct7 == 7'b0000000);
         else if (i_funct3 == 3'b101)
            o_alu_legal = (i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000);
      end
   end

endmodule

// File: rtl/ctrl.sv
// ctrl: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB[/TRAP]).
// Inputs : i_clk, i_rst_n (async active-low), i_opcode/i_funct3/i_funct7 from IR,
//          i_mem_ack (memory completes request this cycle), i_br_taken (valid in EXEC).
// Outputs: IR/PC/RF enables and selects, ALU op/operand/immediate selects,
//          shared memory request (req/we/addr_sel/size), o_retire pulse, o_trap.
// Outputs are combinational from state and fields; all forced to 0 while reset
// is asserted, so a pending memory request drops the moment reset goes low.
// Macro CTRL_TRAP_EN: when defined, illegal instructions lock into TRAP with
// o_trap=1; when undefined, illegal instructions retire as a no-op like FENCE.
module ctrl
   import ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   input  logic       i_mem_ack,
   input  logic       i_br_taken,
   output logic       o_ir_we,
   output logic       o_pc_we,
   output logic       o_pc_sel,
   output logic       o_rf_we,
   output logic [1:0] o_rf_wsel,
   output logic [3:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic [2:0] o_imm_sel,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output logic       o_mem_addr_sel,
   output logic [1:0] o_mem_size,
   output logic       o_retire,
   output logic       o_trap
);

   state_e    state;
   ctrl_sig_t sig, sig_o;
   logic [3:0] alu_op;
   logic       alu_legal, illegal;
   logic       is_load, is_store, is_branch, is_jump, is_fence, exec_fence, sel_en;

   ctrl_aludec u_aludec (
      .i_opcode   (i_opcode),
      .i_funct3   (i_funct3),
      .i_funct7   (i_funct7),
      .o_alu_op   (alu_op),
      .o_alu_legal(alu_legal)
   );

   assign illegal   = insn_illegal(i_opcode, i_funct3, alu_legal);
   assign is_load   = (i_opcode == OPC_LOAD);
   assign is_store  = (i_opcode == OPC_STORE);
   assign is_branch = (i_opcode == OPC_BRANCH);
   assign is_jump   = (i_opcode == OPC_JAL) || (i_opcode == OPC_JALR);
   assign is_fence  = (i_opcode == OPC_FENCE);

   // EXEC-terminating no-op path. With traps enabled an illegal instruction
   // never gets past DECODE, so only FENCE takes it.
`ifdef CTRL_TRAP_EN
   assign exec_fence = is_fence;
`else
   assign exec_fence = is_fence || illegal;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_FETCH;
      end else begin
         case (state)
            ST_FETCH:  if (i_mem_ack) state <= ST_DECODE;
`ifdef CTRL_TRAP_EN
            ST_DECODE: state <= illegal ? ST_TRAP : ST_EXEC;
            ST_TRAP:   state <= ST_TRAP;
`else
            ST_DECODE: state <= ST_EXEC;
`endif
            ST_EXEC: begin
               if (exec_fence || is_branch)  state <= ST_FETCH;
               else if (is_load || is_store) state <= ST_MEM;
               else                          state <= ST_WB;
            end
            ST_MEM:    if (i_mem_ack) state <= is_load ? ST_WB : ST_FETCH;
            ST_WB:     state <= ST_FETCH;
            default:   state <= ST_FETCH;
         endcase
      end
   end

   // ALU selects are held from DECODE through WB: the ALU result feeds the
   // memory address in MEM and the write data / jump target in WB.
   assign sel_en = (state == ST_DECODE) || (state == ST_EXEC) ||
                   (state == ST_MEM)    || (state == ST_WB);

   always_comb begin
      sig = '0;
      if (sel_en) begin
         sig.alu_op = alu_op;
         case (i_opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin sig.alu_src_b = 1'b1; sig.imm_sel = IMM_I; end
            OPC_STORE:  begin sig.alu_src_b = 1'b1; sig.imm_sel = IMM_S; end
            OPC_LUI:    begin sig.alu_src_b = 1'b1; sig.imm_sel = IMM_U; end
            OPC_AUIPC:  begin sig.alu_src_a = 1'b1; sig.alu_src_b = 1'b1; sig.imm_sel = IMM_U; end
            OPC_JAL:    begin sig.alu_src_a = 1'b1; sig.alu_src_b = 1'b1; sig.imm_sel = IMM_J; end
            // ALU forms PC+imm as the target; the compare result arrives on i_br_taken
            OPC_BRANCH: begin sig.alu_src_a = 1'b1; sig.alu_src_b = 1'b1; sig.imm_sel = IMM_B; end
            default: ;
         endcase
      end
      case (state)
         ST_FETCH: begin
            sig.mem_req  = 1'b1;
            sig.mem_size = SIZE_WORD;
            sig.ir_we    = i_mem_ack;
         end
         ST_EXEC: begin
            if (exec_fence) begin
               sig.pc_we  = 1'b1;
               sig.retire = 1'b1;
            end else if (is_branch) begin
               sig.pc_we  = 1'b1;
               sig.pc_sel = i_br_taken;
               sig.retire = 1'b1;
            end
         end
         ST_MEM: begin
            sig.mem_req      = 1'b1;
            sig.mem_addr_sel = 1'b1;
            sig.mem_we       = is_store;
            sig.mem_size     = i_funct3[1:0];
            if (i_mem_ack && is_store) begin
               sig.pc_we  = 1'b1;
               sig.retire = 1'b1;
            end
         end
         ST_WB: begin
            sig.rf_we  = 1'b1;
            sig.pc_we  = 1'b1;
            sig.retire = 1'b1;
            if (is_jump) begin
               sig.rf_wsel = WSEL_PC4;
               sig.pc_sel  = 1'b1;
            end else if (is_load) begin
               sig.rf_wsel = WSEL_MEM;
            end else begin
               sig.rf_wsel = WSEL_ALU;
            end
         end
`ifdef CTRL_TRAP_EN
         ST_TRAP: sig.trap = 1'b1;
`endif
         default: ;
      endcase
   end

   assign sig_o = i_rst_n ? sig : '0;

   assign o_ir_we        = sig_o.ir_we;
   assign o_pc_we        = sig_o.pc_we;
   assign o_pc_sel       = sig_o.pc_sel;
   assign o_rf_we        = sig_o.rf_we;
   assign o_rf_wsel      = sig_o.rf_wsel;
   assign o_alu_op       = sig_o.alu_op;
   assign o_alu_src_a    = sig_o.alu_src_a;
   assign o_alu_src_b    = sig_o.alu_src_b;
   assign o_imm_sel      = sig_o.imm_sel;
   assign o_mem_req      = sig_o.mem_req;
   assign o_mem_we       = sig_o.mem_we;
   assign o_mem_addr_sel = sig_o.mem_addr_sel;
   assign o_mem_size     = sig_o.mem_size;
   assign o_retire       = sig_o.retire;
   assign o_trap         = sig_o.trap;

endmodule

// File: tb/tb_ctrl.sv
// tb_ctrl: self-checking bench for ctrl. Each test pushes per-cycle stimulus
// and expected outputs into a scoreboard, then run_sb drives and compares.
`timescale 1ns/1ps
module tb_ctrl;
   import ctrl_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [6:0] i_opcode;
   logic [2:0] i_funct3;
   logic [6:0] i_funct7;
   logic       i_mem_ack, i_br_taken;
   logic       o_ir_we, o_pc_we, o_pc_sel, o_rf_we;
   logic [1:0] o_rf_wsel;
   logic [3:0] o_alu_op;
   logic       o_alu_src_a, o_alu_src_b;
   logic [2:0] o_imm_sel;
   logic       o_mem_req, o_mem_we, o_mem_addr_sel;
   logic [1:0] o_mem_size;
   logic       o_retire, o_trap;

   always #5 i_clk = ~i_clk;

   ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
      .i_funct7(i_funct7), .i_mem_ack(i_mem_ack), .i_br_taken(i_br_taken),
      .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_rf_we(o_rf_we),
      .o_rf_wsel(o_rf_wsel), .o_alu_op(o_alu_op), .o_alu_src_a(o_alu_src_a),
      .o_alu_src_b(o_alu_src_b), .o_imm_sel(o_imm_sel), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr_sel(o_mem_addr_sel), .o_mem_size(o_mem_size),
      .o_retire(o_retire), .o_trap(o_trap)
   );

   typedef struct packed {
      logic ir_we, pc_we, pc_sel, rf_we;
      logic [1:0] wsel;
      logic [3:0] alu_op;
      logic mem_req, mem_we, addr_sel;
      logic [1:0] size;
      logic retire, trap;
   } obs_t;

   typedef struct packed {
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       ack;
      logic       br;
   } stim_t;

   typedef enum {K_ALU, K_JUMP, K_LOAD, K_STORE, K_BRANCH, K_FENCE} kind_e;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   obs_t  msk_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   obs_t  obs;

   assign obs = {o_ir_we, o_pc_we, o_pc_sel, o_rf_we, o_rf_wsel, o_alu_op,
                 o_mem_req, o_mem_we, o_mem_addr_sel, o_mem_size, o_retire, o_trap};

   // Enables are always checked; selects only where they carry meaning.
   task automatic push_cyc(string nm, stim_t s, obs_t e, logic care_alu, logic care_size);
      obs_t m;
      m = '0;
      m.ir_we = 1'b1; m.pc_we = 1'b1; m.rf_we = 1'b1;
      m.mem_req = 1'b1; m.retire = 1'b1; m.trap = 1'b1;
      m.pc_sel   = e.pc_we;
      m.wsel     = {2{e.rf_we}};
      m.mem_we   = e.mem_req;
      m.addr_sel = e.mem_req;
      m.size     = {2{care_size}};
      m.alu_op   = {4{care_alu}};
      stim_q.push_back(s);
      exp_q.push_back(e);
      msk_q.push_back(m);
      name_q.push_back(nm);
   endtask

   task automatic push_instr(string nm, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                             kind_e k, int fw, int mw, logic br, logic [3:0] aop, logic care_alu);
      stim_t s;
      obs_t  e;
      s.opc = opc; s.f3 = f3; s.f7 = f7; s.br = br;
      for (int i = 0; i < fw; i++) begin
         s.ack = 1'b0; e = '0; e.mem_req = 1'b1;
         push_cyc({nm, ".fetch_wait"}, s, e, 1'b0, 1'b0);
      end
      s.ack = 1'b1; e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
      push_cyc({nm, ".fetch"}, s, e, 1'b0, 1'b0);
      s.ack = 1'($urandom_range(0, 1)); e = '0;
      push_cyc({nm, ".decode"}, s, e, 1'b0, 1'b0);
      s.ack = 1'($urandom_range(0, 1)); e = '0; e.alu_op = aop;
      if (k == K_BRANCH) begin e.pc_we = 1'b1; e.pc_sel = br; e.retire = 1'b1; end
      if (k == K_FENCE)  begin e.pc_we = 1'b1; e.pc_sel = 1'b0; e.retire = 1'b1; end
      push_cyc({nm, ".exec"}, s, e, care_alu, 1'b0);
      if (k == K_LOAD || k == K_STORE) begin
         for (int i = 0; i <= mw; i++) begin
            s.ack = (i == mw);
            e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
            e.mem_we = (k == K_STORE); e.size = f3[1:0];
            if (i == mw && k == K_STORE) begin e.pc_we = 1'b1; e.retire = 1'b1; end
            push_cyc({nm, (i == mw) ? ".mem_ack" : ".mem_wait"}, s, e, 1'b0, 1'b1);
         end
      end
      if (k == K_ALU || k == K_JUMP || k == K_LOAD) begin
         s.ack = 1'($urandom_range(0, 1));
         e = '0; e.alu_op = aop; e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
         e.wsel   = (k == K_JUMP) ? 2'd2 : (k == K_LOAD) ? 2'd1 : 2'd0;
         e.pc_sel = (k == K_JUMP);
         push_cyc({nm, ".wb"}, s, e, care_alu && (k == K_ALU), 1'b0);
      end
   endtask

   task automatic push_trap(string nm, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
      stim_t s;
      obs_t  e;
      s.opc = opc; s.f3 = f3; s.f7 = f7; s.br = 1'b0;
      s.ack = 1'b1; e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
      push_cyc({nm, ".fetch"}, s, e, 1'b0, 1'b0);
      s.ack = 1'b0; e = '0;
      push_cyc({nm, ".decode"}, s, e, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         s.ack = 1'b1; e = '0; e.trap = 1'b1;
         push_cyc({nm, ".trap"}, s, e, 1'b0, 1'b0);
      end
   endtask

   // Entered and left at posedge+1; outputs sampled on the falling edge.
   task automatic run_sb();
      stim_t s;
      obs_t  e, m;
      string nm;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         m = msk_q.pop_front();  nm = name_q.pop_front();
         i_opcode = s.opc; i_funct3 = s.f3; i_funct7 = s.f7;
         i_mem_ack = s.ack; i_br_taken = s.br;
         @(negedge i_clk);
         n_checks++;
         if ((obs & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (mask %h)", nm, obs & m, e & m, m);
         end
         @(posedge i_clk); #1;
      end
   endtask

   task automatic check_zero(string nm);
      logic [21:0] all;
      all = {o_ir_we, o_pc_we, o_pc_sel, o_rf_we, o_rf_wsel, o_alu_op, o_alu_src_a,
             o_alu_src_b, o_imm_sel, o_mem_req, o_mem_we, o_mem_addr_sel, o_mem_size,
             o_retire, o_trap};
      n_checks++;
      if (all !== 22'd0) begin
         n_fail++;
         $display("FAIL %s: outputs %h want 0", nm, all);
      end
   endtask

   task automatic do_reset(string nm);
      i_mem_ack = 1'b1;
      i_rst_n = 1'b0;
      #1 check_zero({nm, ".asserted"});
      @(posedge i_clk); #1;
      check_zero({nm, ".held"});
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_mem_ack = 1'b1; i_br_taken = 1'b1;
      i_opcode = OPC_OP; i_funct3 = 3'b000; i_funct7 = 7'b0000000;
      repeat (2) @(posedge i_clk);
      #1 check_zero("reset");
      do_reset("reset");
   endtask

   task automatic test_alu();
      push_instr("add",   OPC_OP,    3'b000, 7'b0000000, K_ALU, 0, 0, 0, ALU_ADD,    1);
      push_instr("sub",   OPC_OP,    3'b000, 7'b0100000, K_ALU, 0, 0, 0, ALU_SUB,    1);
      push_instr("sra",   OPC_OP,    3'b101, 7'b0100000, K_ALU, 0, 0, 0, ALU_SRA,    1);
      push_instr("sltu",  OPC_OP,    3'b011, 7'b0000000, K_ALU, 0, 0, 0, ALU_SLTU,   1);
      push_instr("xor",   OPC_OP,    3'b100, 7'b0000000, K_ALU, 0, 0, 0, ALU_XOR,    1);
      push_instr("andi",  OPC_OPIMM, 3'b111, 7'b1010101, K_ALU, 0, 0, 0, ALU_AND,    1);
      push_instr("addi",  OPC_OPIMM, 3'b000, 7'b0100000, K_ALU, 0, 0, 0, ALU_ADD,    1);
      push_instr("srai",  OPC_OPIMM, 3'b101, 7'b0100000, K_ALU, 0, 0, 0, ALU_SRA,    1);
      push_instr("slli",  OPC_OPIMM, 3'b001, 7'b0000000, K_ALU, 0, 0, 0, ALU_SLL,    1);
      push_instr("lui",   OPC_LUI,   3'b110, 7'b1111111, K_ALU, 0, 0, 0, ALU_PASS_B, 1);
      push_instr("auipc", OPC_AUIPC, 3'b010, 7'b0011001, K_ALU, 1, 0, 0, ALU_ADD,    1);
      run_sb();
   endtask

   task automatic test_load_wait();
      push_instr("lw",  OPC_LOAD, 3'b010, 7'd0, K_LOAD, 0, 2, 0, ALU_ADD, 1);
      push_instr("lbu", OPC_LOAD, 3'b100, 7'd0, K_LOAD, 1, 0, 0, ALU_ADD, 1);
      push_instr("lh",  OPC_LOAD, 3'b001, 7'd0, K_LOAD, 0, 1, 0, ALU_ADD, 1);
      run_sb();
   endtask

   task automatic test_store();
      push_instr("sw", OPC_STORE, 3'b010, 7'd0, K_STORE, 0, 0, 0, ALU_ADD, 1);
      push_instr("sb", OPC_STORE, 3'b000, 7'd0, K_STORE, 2, 1, 0, ALU_ADD, 1);
      run_sb();
   endtask

   task automatic test_branch();
      push_instr("beq_t", OPC_BRANCH, 3'b000, 7'd0, K_BRANCH, 0, 0, 1, ALU_ADD, 0);
      push_instr("beq_n", OPC_BRANCH, 3'b000, 7'd0, K_BRANCH, 0, 0, 0, ALU_ADD, 0);
      push_instr("bgeu",  OPC_BRANCH, 3'b111, 7'd0, K_BRANCH, 1, 0, 1, ALU_ADD, 0);
      run_sb();
   endtask

   task automatic test_jump();
      push_instr("jal",  OPC_JAL,  3'b101, 7'd9, K_JUMP, 0, 0, 0, ALU_ADD, 1);
      push_instr("jalr", OPC_JALR, 3'b000, 7'd0, K_JUMP, 0, 0, 0, ALU_ADD, 1);
      push_instr("fence", OPC_FENCE, 3'b000, 7'd0, K_FENCE, 0, 0, 1, ALU_ADD, 0);
      run_sb();
   endtask

   task automatic test_illegal();
      logic [16:0] tbl [7];
      tbl[0] = {7'b0000000, 3'b000, 7'b0000000};
      tbl[1] = {OPC_SYSTEM, 3'b000, 7'b0000000};
      tbl[2] = {OPC_JALR,   3'b001, 7'b0000000};
      tbl[3] = {OPC_OP,     3'b000, 7'b0000001};
      tbl[4] = {OPC_LOAD,   3'b011, 7'b0000000};
      tbl[5] = {OPC_OPIMM,  3'b001, 7'b0100000};
      tbl[6] = {OPC_OP,     3'b111, 7'b0100000};
      for (int i = 0; i < 7; i++) begin
`ifdef CTRL_TRAP_EN
         push_trap($sformatf("illegal%0d", i), tbl[i][16:10], tbl[i][9:7], tbl[i][6:0]);
         run_sb();
         do_reset($sformatf("illegal%0d_rst", i));
`else
         push_instr($sformatf("illegal%0d", i), tbl[i][16:10], tbl[i][9:7], tbl[i][6:0],
                    K_FENCE, 0, 0, 1, ALU_ADD, 0);
         run_sb();
`endif
      end
   endtask

   task automatic test_reset_mid();
      i_opcode = OPC_OP; i_funct3 = 3'b000; i_funct7 = 7'd0; i_mem_ack = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_mem_req !== 1'b1 || o_ir_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid.wait: req=%b ir_we=%b want 1/0", o_mem_req, o_ir_we);
      end
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      #1 check_zero("rst_mid.drop");
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      push_instr("rst_mid.add", OPC_OP, 3'b000, 7'd0, K_ALU, 0, 0, 0, ALU_ADD, 1);
      run_sb();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         push_instr("b2b.sub", OPC_OP, 3'b000, 7'b0100000, K_ALU,
                    $urandom_range(0, 2), 0, 0, ALU_SUB, 1);
         push_instr("b2b.lw", OPC_LOAD, 3'b010, 7'd0, K_LOAD,
                    $urandom_range(0, 2), $urandom_range(0, 2), 0, ALU_ADD, 1);
         push_instr("b2b.bne", OPC_BRANCH, 3'b001, 7'd0, K_BRANCH,
                    0, 0, 1'($urandom_range(0, 1)), ALU_ADD, 0);
         push_instr("b2b.sh", OPC_STORE, 3'b001, 7'd0, K_STORE,
                    $urandom_range(0, 2), $urandom_range(0, 2), 0, ALU_ADD, 1);
      end
      run_sb();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
